ram_arbiter: RTL and testbench

Two-port arbiter that shares one single-port synchronous RAM between requesters A and B. It sits directly in front of the RAM macro, with R-bit address and 2**W-bit data. Each cycle it grants at most one access, using sticky round-robin with a burst cap so neither side starves. It then routes the registered RAM read data back to the requester that issued the read.

---
 rtl/ram_arbiter_if.sv | 73 +++++++
 rtl/ram_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the two requester ports, the RAM macro port and the arbiter's
// debug state into one interface.
//
// Handshake (both requesters): req_x is a request held with a stable
// command (wr_rd_x, addr_x, din_x) until gnt_x is seen. gnt_x is
// combinational; the command is consumed on the rising edge where
// gnt_x = 1. In the next cycle the requester may drop req_x or present a
// new command. Dropping req_x before a grant withdraws the request.
// A read granted in cycle N returns in cycle N+1 with rvalid_x = 1 and
// rdata valid.
//
// Modports:
//   slave  - the arbiter: takes requests and ram_d_out; drives grants,
//            read return, RAM command and debug state.
//   master - the environment (requesters plus the RAM macro).
interface ram_arbiter_if #(
    parameter int R    = 7,
    parameter int W    = 4,
    parameter int MAXB = 4
);
    localparam int D  = 1 << W;
    localparam int CW = $clog2(MAXB + 1);

    // Requester A
    logic         req_a;
    logic         wr_rd_a;
    logic [R-1:0] addr_a;
    logic [D-1:0] din_a;
    logic         gnt_a;
    logic         rvalid_a;

    // Requester B
    logic         req_b;
    logic         wr_rd_b;
    logic [R-1:0] addr_b;
    logic [D-1:0] din_b;
    logic         gnt_b;
    logic         rvalid_b;

    // Shared read return
    logic [D-1:0] rdata;

    // RAM macro port
    logic         ram_wr_rd;
    logic [R-1:0] ram_addr;
    logic [D-1:0] ram_d_in;
    logic [D-1:0] ram_d_out;

    // Debug view of the arbiter state
    logic          dbg_owner;
    logic [CW-1:0] dbg_cnt;
    logic          dbg_pend_v;
    logic          dbg_pend_id;

    modport slave (
        input  req_a, wr_rd_a, addr_a, din_a,
        input  req_b, wr_rd_b, addr_b, din_b,
        input  ram_d_out,
        output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
        output ram_wr_rd, ram_addr, ram_d_in,
        output dbg_owner, dbg_cnt, dbg_pend_v, dbg_pend_id
    );

    modport master (
        output req_a, wr_rd_a, addr_a, din_a,
        output req_b, wr_rd_b, addr_b, din_b,
        output ram_d_out,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
        input  ram_wr_rd, ram_addr, ram_d_in,
        input  dbg_owner, dbg_cnt, dbg_pend_v, dbg_pend_id
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between requesters A and B.
// At most one access is granted per cycle using sticky round-robin with a
// burst cap: the last grantee (owner) keeps winning under contention until
// it has had MAXB consecutive grants, then the other side wins. Read data
// from the RAM (registered, one cycle after the read edge) is tagged back
// to the requester that issued the read.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - ram_arbiter_if.slave: requester ports, RAM port, debug state
module ram_arbiter #(
    parameter int R    = 7,
    parameter int W    = 4,
    parameter int MAXB = 4
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);
    localparam int D  = 1 << W;
    localparam int CW = $clog2(MAXB + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXB);

    typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_e;

    side_e         owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_v_q, pend_v_d;
    side_e         pend_id_q, pend_id_d;

    logic  grant_a, grant_b, grant_any, grant_rd;
    side_e grantee;

    // Arbitration. Under contention the owner keeps the bus only while its
    // run is below the cap; a lone requester always wins regardless of cnt.
    always_comb begin : arbitrate
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (bus.req_a && bus.req_b) begin
            if (cnt_q < CNT_MAX) begin
                grant_a = (owner_q == SIDE_A);
                grant_b = (owner_q == SIDE_B);
            end else begin
                grant_a = (owner_q == SIDE_B);
                grant_b = (owner_q == SIDE_A);
            end
        end else if (bus.req_a) begin
            grant_a = 1'b1;
        end else if (bus.req_b) begin
            grant_b = 1'b1;
        end
    end

    assign grant_any = grant_a | grant_b;
    assign grantee   = grant_b ? SIDE_B : SIDE_A;
    assign grant_rd  = (grant_a && !bus.wr_rd_a) || (grant_b && !bus.wr_rd_b);

    // RAM command mux. With no grant the RAM sees a harmless read of addr 0.
    always_comb begin : ram_drive
        bus.ram_wr_rd = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_d_in  = '0;
        if (grant_a) begin
            bus.ram_wr_rd = bus.wr_rd_a;
            bus.ram_addr  = bus.addr_a;
            bus.ram_d_in  = bus.din_a;
        end else if (grant_b) begin
            bus.ram_wr_rd = bus.wr_rd_b;
            bus.ram_addr  = bus.addr_b;
            bus.ram_d_in  = bus.din_b;
        end
    end

    // Next state: run counter, owner and in-flight read tag.
    always_comb begin : next_state
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        pend_v_d  = 1'b0;
        pend_id_d = pend_id_q;
        if (grant_any) begin
            if (grantee == owner_q) begin
                if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                owner_d = grantee;
                cnt_d   = CW'(1);
            end
            if (grant_rd) begin
                pend_v_d  = 1'b1;
                pend_id_d = grantee;
            end
        end else begin
            // An idle cycle ends the run so the owner starts fresh.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= SIDE_A;
            cnt_q     <= '0;
            pend_v_q  <= 1'b0;
            pend_id_q <= SIDE_A;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
        end
    end

    assign bus.gnt_a    = grant_a;
    assign bus.gnt_b    = grant_b;
    assign bus.rvalid_a = pend_v_q && (pend_id_q == SIDE_A);
    assign bus.rvalid_b = pend_v_q && (pend_id_q == SIDE_B);
    assign bus.rdata    = bus.ram_d_out;

    assign bus.dbg_owner   = owner_q;
    assign bus.dbg_cnt     = cnt_q;
    assign bus.dbg_pend_v  = pend_v_q;
    assign bus.dbg_pend_id = pend_id_q;

    // D is the data width carried by the interface; keep the relation visible.
    logic [D-1:0] unused_width_ref;
    assign unused_width_ref = bus.din_a ^ bus.din_a;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a synchronous RAM model, a
// grant-history reference model checked every cycle, and literal
// expectations for the key scenarios.
module tb_ram_arbiter;
    localparam int R     = 7;
    localparam int W     = 4;
    localparam int MAXB  = 4;
    localparam int D     = 1 << W;
    localparam int DEPTH = 1 << R;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    ram_arbiter_if #(.R(R), .W(W), .MAXB(MAXB)) bus ();

    ram_arbiter #(.R(R), .W(W), .MAXB(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM macro model ----------------
    logic [D-1:0] ram_mem [0:DEPTH-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        bus.ram_d_out = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_wr_rd) ram_mem[bus.ram_addr] <= bus.ram_d_in;
        else               bus.ram_d_out <= ram_mem[bus.ram_addr];
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the list of grantees per cycle (-1 = idle) and derives who owns
    // the bus and how long its current run is from that history.
    int           ghist[$];
    logic [D-1:0] m_mem [0:DEPTH-1];
    bit           m_pend_v;
    int           m_pend_id;
    logic [D-1:0] m_pend_data;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_pend_v    = 1'b0;
        m_pend_id   = 0;
        m_pend_data = '0;
    end

    function automatic int model_owner();
        for (int i = ghist.size() - 1; i >= 0; i--)
            if (ghist[i] >= 0) return ghist[i];
        return 0;
    endfunction

    function automatic int model_run();
        int n;
        int last;
        n = 0;
        if (ghist.size() == 0) return 0;
        last = ghist[ghist.size() - 1];
        if (last < 0) return 0;
        for (int i = ghist.size() - 1; i >= 0; i--) begin
            if (ghist[i] != last) break;
            n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin : model_cmp
        int           eg;
        int           own;
        logic         e_wr;
        logic [R-1:0] e_addr;
        logic [D-1:0] e_din;

        if (!rst) begin
            ghist.delete();
            m_pend_v = 1'b0;
        end

        check("rvalid_a", 32'(bus.rvalid_a), 32'(m_pend_v && m_pend_id == 0));
        check("rvalid_b", 32'(bus.rvalid_b), 32'(m_pend_v && m_pend_id == 1));
        if (m_pend_v) check("rdata", 32'(bus.rdata), 32'(m_pend_data));

        own = model_owner();
        eg  = -1;
        if (bus.req_a && bus.req_b) eg = (model_run() < MAXB) ? own : 1 - own;
        else if (bus.req_a)         eg = 0;
        else if (bus.req_b)         eg = 1;

        check("gnt_a", 32'(bus.gnt_a), 32'(eg == 0));
        check("gnt_b", 32'(bus.gnt_b), 32'(eg == 1));

        e_wr = 1'b0; e_addr = '0; e_din = '0;
        if (eg == 0) begin
            e_wr = bus.wr_rd_a; e_addr = bus.addr_a; e_din = bus.din_a;
        end else if (eg == 1) begin
            e_wr = bus.wr_rd_b; e_addr = bus.addr_b; e_din = bus.din_b;
        end
        check("ram_wr_rd", 32'(bus.ram_wr_rd), 32'(e_wr));
        check("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
        check("ram_d_in",  32'(bus.ram_d_in),  32'(e_din));

        if (rst) begin
            ghist.push_back(eg);
            m_pend_v = 1'b0;
            if (eg >= 0 && !e_wr) begin
                m_pend_v    = 1'b1;
                m_pend_id   = eg;
                m_pend_data = m_mem[e_addr];
            end
            if (eg >= 0 && e_wr) m_mem[e_addr] = e_din;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [R-1:0] addr, input logic [D-1:0] din);
        bus.req_a = req; bus.wr_rd_a = wr; bus.addr_a = addr; bus.din_a = din;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [R-1:0] addr, input logic [D-1:0] din);
        bus.req_b = req; bus.wr_rd_b = wr; bus.addr_b = addr; bus.din_b = din;
    endtask

    // ---------------- directed stimulus ----------------
    logic [11:0] seq;
    logic [11:0] seq_exp;
    int          b_grants;

    initial begin
        rst = 1'b0;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rst = 1'b1;

        // Reset then idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt_a",    32'(bus.gnt_a),     32'd0);
            check("idle_gnt_b",    32'(bus.gnt_b),     32'd0);
            check("idle_rvalid_a", 32'(bus.rvalid_a),  32'd0);
            check("idle_rvalid_b", 32'(bus.rvalid_b),  32'd0);
            check("idle_ram_wr",   32'(bus.ram_wr_rd), 32'd0);
            tick();
        end

        // A writes 0x1234 to addr 5, then reads it back.
        set_a(1'b1, 1'b1, 7'd5, 16'h1234);
        @(negedge clk);
        check("wr5_gnt_a", 32'(bus.gnt_a), 32'd1);
        tick();
        set_a(1'b1, 1'b0, 7'd5, 16'h0000);
        @(negedge clk);
        check("rd5_gnt_a", 32'(bus.gnt_a), 32'd1);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rd5_rvalid_a", 32'(bus.rvalid_a), 32'd1);
        check("rd5_rdata",    32'(bus.rdata),    32'h1234);
        check("rd5_rvalid_b", 32'(bus.rvalid_b), 32'd0);
        tick();

        // Continuous contention: AAAA BBBB AAAA.
        set_a(1'b1, 1'b0, 7'd5, '0);
        set_b(1'b1, 1'b0, 7'd9, '0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seq[i] = bus.gnt_b;
            tick();
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        seq_exp = 12'b0000_1111_0000;
        check("rr_pattern", 32'(seq), 32'(seq_exp));
        tick();

        // From reset: A reads 0x7F while B writes 0x00FF to 0x7F.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 7'h7F, '0);
        set_b(1'b1, 1'b1, 7'h7F, 16'h00FF);
        @(negedge clk);
        check("race_c1_gnt_a", 32'(bus.gnt_a), 32'd1);
        check("race_c1_gnt_b", 32'(bus.gnt_b), 32'd0);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("race_c2_gnt_b",  32'(bus.gnt_b),    32'd1);
        check("race_c2_rvalid", 32'(bus.rvalid_a), 32'd1);
        check("race_c2_old",    32'(bus.rdata),    32'h0000);
        tick();
        set_b(1'b0, 1'b0, '0, '0);
        set_a(1'b1, 1'b0, 7'h7F, '0);
        @(negedge clk);
        check("race_c3_gnt_a", 32'(bus.gnt_a), 32'd1);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("race_c4_rvalid", 32'(bus.rvalid_a), 32'd1);
        check("race_c4_new",    32'(bus.rdata),    32'h00FF);
        tick();

        // B alone for 20 cycles, then A joins and wins at once.
        b_grants = 0;
        for (int i = 0; i < 20; i++) begin
            set_b(1'b1, 1'b0, 7'(i), '0);
            @(negedge clk);
            if (bus.gnt_b) b_grants++;
            tick();
        end
        check("solo_b_grants", 32'(b_grants), 32'd20);
        check("solo_b_cnt_sat", 32'(bus.dbg_cnt), 32'd4);
        set_a(1'b1, 1'b0, 7'd5, '0);
        @(negedge clk);
        check("join_gnt_a", 32'(bus.gnt_a), 32'd1);
        check("join_gnt_b", 32'(bus.gnt_b), 32'd0);
        tick();

        // B read in flight, then reset for one cycle.
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b1, 1'b0, 7'h7F, '0);
        @(negedge clk);
        check("pre_rst_gnt_b", 32'(bus.gnt_b), 32'd1);
        tick();
        rst = 1'b0;
        set_b(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_rvalid_b", 32'(bus.rvalid_b), 32'd0);
        check("rst_rvalid_a", 32'(bus.rvalid_a), 32'd0);
        tick();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 7'd1, '0);
        set_b(1'b1, 1'b0, 7'd2, '0);
        @(negedge clk);
        check("post_rst_gnt_a",    32'(bus.gnt_a),    32'd1);
        check("post_rst_no_stale", 32'(bus.rvalid_b), 32'd0);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("post_rst_a_rvalid", 32'(bus.rvalid_a), 32'd1);
        tick();
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
